// File: rtl/poly_note_pkg.sv
// Shared types and saturating arithmetic for the polyphonic note bank.
package poly_note_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    // Envelope arithmetic is done in a fixed 32-bit word; callers zero-extend and truncate.
    typedef logic [31:0] amp_word_t;

    function automatic amp_word_t sat_add(input amp_word_t a, input amp_word_t b,
                                          input amp_word_t ceil_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil_val}) ? ceil_val : sum[31:0];
    endfunction

    function automatic amp_word_t sat_sub(input amp_word_t a, input amp_word_t b,
                                          input amp_word_t floor_val);
        if (b >= a)
            return floor_val;
        return ((a - b) < floor_val) ? floor_val : (a - b);
    endfunction

endpackage

// File: rtl/poly_voice.sv
// One voice: ADSR envelope FSM, square-wave tone counter and signed sample output.
module poly_voice
    import poly_note_pkg::*;
#(
    parameter int PERIOD_W = 26,
    parameter int AMP_W    = 16
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                en,
    input  logic                start,
    input  logic                zero_level,
    input  logic                rel_cmd,
    input  logic [6:0]          new_key,
    input  logic [PERIOD_W-1:0] new_period,
    input  logic [AMP_W-1:0]    atk_step,
    input  logic [AMP_W-1:0]    dec_step,
    input  logic [AMP_W-1:0]    rel_step,
    input  logic [AMP_W-1:0]    sus_level,
    output env_state_t          state,
    output logic [6:0]          key,
    output logic                busy,
    output logic                done,
    output logic signed [AMP_W:0] sample
);

    localparam logic [AMP_W-1:0] AMP_MAX = '1;

    env_state_t          state_reg, state_next;
    logic [AMP_W-1:0]    level_reg, level_next;
    logic [PERIOD_W-1:0] cnt_reg, cnt_next;
    logic [PERIOD_W-1:0] period_reg;
    logic [6:0]          key_reg;
    logic                phase_reg, phase_next;
    logic                done_reg, done_next;

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        done_next  = 1'b0;
        if (en) begin
            case (state_reg)
                ATTACK: if (atk_step != '0) begin
                    level_next = AMP_W'(sat_add(amp_word_t'(level_reg), amp_word_t'(atk_step),
                                                amp_word_t'(AMP_MAX)));
                    if (level_next == AMP_MAX)
                        state_next = DECAY;
                end
                DECAY: if (dec_step != '0) begin
                    level_next = AMP_W'(sat_sub(amp_word_t'(level_reg), amp_word_t'(dec_step),
                                                amp_word_t'(sus_level)));
                    if (level_next == sus_level)
                        state_next = SUSTAIN;
                end
                SUSTAIN: level_next = sus_level;
                RELEASE: if (rel_step != '0) begin
                    level_next = AMP_W'(sat_sub(amp_word_t'(level_reg), amp_word_t'(rel_step),
                                                amp_word_t'(0)));
                    if (level_next == '0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_reg != IDLE) begin
                if (period_reg == '0) begin
                    cnt_next   = '0;
                    phase_next = 1'b1;
                end else if (cnt_reg >= period_reg - 1'b1) begin
                    cnt_next   = '0;
                    phase_next = ~phase_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end
        // Commands land regardless of en; a (re)start overrides any envelope progress this cycle.
        if (start) begin
            state_next = ATTACK;
            level_next = zero_level ? '0 : level_reg;
            cnt_next   = '0;
            phase_next = 1'b1;
            done_next  = 1'b0;
        end else if (rel_cmd) begin
            state_next = RELEASE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg  <= IDLE;
            level_reg  <= '0;
            cnt_reg    <= '0;
            phase_reg  <= 1'b1;
            period_reg <= '0;
            key_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            done_reg  <= done_next;
            if (start) begin
                period_reg <= new_period;
                key_reg    <= new_key;
            end
        end
    end

    assign state  = state_reg;
    assign key    = key_reg;
    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign sample = (state_reg == IDLE) ? '0 :
                    (phase_reg ? $signed({1'b0, level_reg}) : -$signed({1'b0, level_reg}));

endmodule

// File: rtl/poly_note_bank.sv
// Polyphonic note bank: voice allocation/retrigger and signed mix of NUM_VOICES voices.
// Define POLY_NOTE_BANK_STEAL_EN to steal a voice round-robin when the bank is full.
module poly_note_bank
    import poly_note_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PERIOD_W   = 26,
    parameter int AMP_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  en,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic                  note_on,
    input  logic [6:0]            note_key,
    input  logic [PERIOD_W-1:0]   note_period,
    input  logic [AMP_W-1:0]      atk_step,
    input  logic [AMP_W-1:0]      dec_step,
    input  logic [AMP_W-1:0]      rel_step,
    input  logic [AMP_W-1:0]      sus_level,
    output logic signed [AMP_W+$clog2(NUM_VOICES):0] mix_out,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int MIX_W = AMP_W + 1 + $clog2(NUM_VOICES);

    env_state_t             voice_state  [NUM_VOICES];
    logic [6:0]             voice_key    [NUM_VOICES];
    logic signed [AMP_W:0]  voice_sample [NUM_VOICES];
    logic [NUM_VOICES-1:0]  voice_done, start_vec, rel_vec, on_match, off_match;
    logic [IDX_W-1:0]       on_idx, off_idx, idle_idx, alloc_idx;
    logic                   accept, full_miss, zero_level;
    logic signed [MIX_W-1:0] mix_sum, mix_reg;

    // Lowest index wins for every lookup, so scan from the top down.
    always_comb begin
        on_idx   = '0;
        off_idx  = '0;
        idle_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (on_match[v])    on_idx   = IDX_W'(v);
            if (off_match[v])   off_idx  = IDX_W'(v);
            if (!voice_busy[v]) idle_idx = IDX_W'(v);
        end
    end

    assign full_miss = !(|on_match) && (&voice_busy);
    assign accept    = note_valid && note_ready;

`ifdef POLY_NOTE_BANK_STEAL_EN
    logic [IDX_W-1:0] steal_ptr_reg;

    assign note_ready = 1'b1;
    assign zero_level = full_miss;
    assign alloc_idx  = (|on_match) ? on_idx : (full_miss ? steal_ptr_reg : idle_idx);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            steal_ptr_reg <= '0;
        else if (accept && note_on && full_miss)
            steal_ptr_reg <= (steal_ptr_reg == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_reg + 1'b1;
    end
`else
    assign note_ready = !(note_valid && note_on && full_miss);
    assign zero_level = 1'b0;
    assign alloc_idx  = (|on_match) ? on_idx : idle_idx;
`endif

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        assign on_match[gi]  = voice_busy[gi] && (voice_key[gi] == note_key);
        assign off_match[gi] = ((voice_state[gi] == ATTACK) || (voice_state[gi] == DECAY) ||
                                (voice_state[gi] == SUSTAIN)) && (voice_key[gi] == note_key);
        assign start_vec[gi] = accept && note_on && (alloc_idx == IDX_W'(gi));
        assign rel_vec[gi]   = accept && !note_on && (|off_match) && (off_idx == IDX_W'(gi));

        poly_voice #(
            .PERIOD_W (PERIOD_W),
            .AMP_W    (AMP_W)
        ) u_voice (
            .clk        (clk),
            .rst_b      (rst_b),
            .en         (en),
            .start      (start_vec[gi]),
            .zero_level (zero_level),
            .rel_cmd    (rel_vec[gi]),
            .new_key    (note_key),
            .new_period (note_period),
            .atk_step   (atk_step),
            .dec_step   (dec_step),
            .rel_step   (rel_step),
            .sus_level  (sus_level),
            .state      (voice_state[gi]),
            .key        (voice_key[gi]),
            .busy       (voice_busy[gi]),
            .done       (voice_done[gi]),
            .sample     (voice_sample[gi])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            mix_sum = mix_sum + MIX_W'(voice_sample[v]);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            mix_reg <= '0;
        else
            mix_reg <= mix_sum;
    end

    assign mix_out = mix_reg;
    assign busy    = |voice_busy;
    assign done    = |voice_done;

endmodule

// File: tb/tb_poly_note_bank.sv
// Directed scoreboard bench for poly_note_bank (default parameters).
module tb_poly_note_bank;

    localparam int NV = 4;
    localparam int PW = 26;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic en = 1'b1;
    logic note_valid = 1'b0;
    logic note_on = 1'b0;
    logic [6:0] note_key = '0;
    logic [PW-1:0] note_period = '0;
    logic [AW-1:0] atk_step = '0, dec_step = '0, rel_step = '0, sus_level = '0;
    logic note_ready, busy, done;
    logic [NV-1:0] voice_busy;
    logic signed [AW+2:0] mix_out;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    poly_note_bank #(.NUM_VOICES(NV), .PERIOD_W(PW), .AMP_W(AW)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .en          (en),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_on     (note_on),
        .note_key    (note_key),
        .note_period (note_period),
        .atk_step    (atk_step),
        .dec_step    (dec_step),
        .rel_step    (rel_step),
        .sus_level   (sus_level),
        .mix_out     (mix_out),
        .voice_busy  (voice_busy),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input int obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=%0d expected=queued_entry", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic send(input logic on, input logic [6:0] key, input int period);
        note_valid  = 1'b1;
        note_on     = on;
        note_key    = key;
        note_period = PW'(period);
        tick();
        note_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            tick();
            if (done) seen = 1;
        end
        push(tag, 1);
        pop_check(seen);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mix_tab[20] = '{0, 16384, 32768, 49152, -65535, -61439, -57343, -53247,
                            49151, 45055, 40959, 36863, -32768, -32768, -32768, -32768,
                            32768, 32768, 32768, 32768};
        int got, done_at, ref_mix;

        // Reset state
        tick(); tick();
        push("rst_mix", 0);        pop_check(mix_out);
        push("rst_busy", 0);       pop_check(busy);
        push("rst_voice_busy", 0); pop_check(voice_busy);
        push("rst_ready", 1);      pop_check(note_ready);
        push("rst_done", 0);       pop_check(done);
        rst_b = 1'b1;
        tick();

        // Single note: attack ramp, decay to sustain, tone period 4
        atk_step = 16'h4000; dec_step = 16'h1000; sus_level = 16'h8000; rel_step = 16'h0000;
        send(1'b1, 7'd60, 4);
        push("one_busy", 1); pop_check(voice_busy);
        for (int i = 0; i < 20; i++) begin
            push($sformatf("mix_%0d", i + 1), mix_tab[i]);
            tick();
            pop_check(mix_out);
        end

        // Release from sustain 0x8000 with step 0x8000
        rel_step = 16'h8000;
        send(1'b0, 7'd60, 0);
        push("rel_busy_f0", 1); pop_check(voice_busy);
        push("rel_done_f0", 0); pop_check(done);
        tick();
        push("rel_done_f1", 1);  pop_check(done);
        push("rel_busy_f1", 0);  pop_check(voice_busy);
        push("rel_mix_f1", -32768); pop_check(mix_out);
        tick();
        push("rel_done_f2", 0); pop_check(done);
        push("rel_mix_f2", 0);  pop_check(mix_out);

        // Reset while a note is sustaining
        send(1'b1, 7'd60, 4);
        for (int i = 0; i < 20; i++) tick();
        push("pre_rst_mix_nz", 1); pop_check(mix_out != 0);
        #2 rst_b = 1'b0;
        #1;
        push("midrst_mix", 0);   pop_check(mix_out);
        push("midrst_busy", 0);  pop_check(busy);
        push("midrst_vbusy", 0); pop_check(voice_busy);
        push("midrst_ready", 1); pop_check(note_ready);
        tick();
        rst_b = 1'b1;
        tick();

        // Allocation of four keys, free and reuse voice 1
        rel_step = 16'hFFFF;
        send(1'b1, 7'd60, 4);
        send(1'b1, 7'd62, 5);
        send(1'b1, 7'd64, 6);
        send(1'b1, 7'd65, 7);
        push("alloc_all", 15); pop_check(voice_busy);
        tick(); tick(); tick();
        send(1'b0, 7'd62, 0);
        wait_done("off62_done", 20);
        push("alloc_1101", 13); pop_check(voice_busy);
        send(1'b1, 7'd67, 8);
        push("realloc_all", 15); pop_check(voice_busy);
        tick(); tick(); tick();
        send(1'b0, 7'd67, 0);
        wait_done("off67_done", 20);
        push("v1_holds_67", 13); pop_check(voice_busy);
        send(1'b1, 7'd67, 8);
        push("full_all", 15); pop_check(voice_busy);
        for (int i = 0; i < 20; i++) tick();

`ifndef POLY_NOTE_BANK_STEAL_EN
        // Full bank: fifth note-on stalls until a voice finishes release
        rel_step = 16'h0800;
        send(1'b0, 7'd64, 0);
        note_valid = 1'b1; note_on = 1'b1; note_key = 7'd70; note_period = PW'(9);
        #1;
        push("full_ready0", 0); pop_check(note_ready);
        got = 0; done_at = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            tick();
            if (note_ready) begin
                got = 1;
                done_at = done;
            end
        end
        push("full_ready_bound", 1); pop_check(got);
        push("ready_with_done", 1);  pop_check(done_at);
        tick();
        note_valid = 1'b0;
        push("full_refill", 15); pop_check(voice_busy);
`else
        // Full bank: steal voice 0, then voice 1 on the next steal
        note_valid = 1'b1; note_on = 1'b1; note_key = 7'd70; note_period = PW'(9);
        #1;
        push("steal_ready", 1); pop_check(note_ready);
        tick();
        note_valid = 1'b0;
        push("steal_all", 15); pop_check(voice_busy);
        send(1'b0, 7'd70, 0);
        wait_done("steal_off70_done", 20);
        push("steal_v0_was_70", 14); pop_check(voice_busy);
        send(1'b1, 7'd74, 4);
        send(1'b1, 7'd76, 4);
        push("steal2_all", 15); pop_check(voice_busy);
        send(1'b0, 7'd76, 0);
        wait_done("steal_off76_done", 20);
        push("steal_ptr1_v1", 13); pop_check(voice_busy);
`endif

        // Retrigger same key, then en low freezes output while a note-off is latched
        do_reset();
        atk_step = 16'h4000; dec_step = 16'h1000; sus_level = 16'h8000; rel_step = 16'h1000;
        send(1'b1, 7'd60, 3);
        send(1'b1, 7'd60, 3);
        push("retrig_one_voice", 1); pop_check(voice_busy);
        for (int i = 0; i < 5; i++) tick();
        en = 1'b0;
        tick();
        ref_mix = mix_out;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                note_valid = 1'b1; note_on = 1'b0; note_key = 7'd60;
            end
            push($sformatf("en_hold_%0d", i), ref_mix);
            tick();
            note_valid = 1'b0;
            pop_check(mix_out);
        end
        push("en_hold_busy", 1); pop_check(voice_busy);
        en = 1'b1;
        wait_done("en_release_done", 40);
        push("en_release_idle", 0); pop_check(voice_busy);

        // Zero attack step holds the voice in attack at level 0
        atk_step = 16'h0000;
        send(1'b1, 7'd50, 2);
        for (int i = 0; i < 5; i++) tick();
        push("zero_atk_busy", 1); pop_check(voice_busy);
        push("zero_atk_mix", 0);  pop_check(mix_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
